// File: rtl/tlb_pkg.sv
// Shared TLB types: entry layout, page-size codes, INVTLB op codes, sweep FSM states.
package tlb_pkg;

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_2M = 6'd21;

  localparam logic [4:0] INV_ALL0       = 5'd0;
  localparam logic [4:0] INV_ALL1       = 5'd1;
  localparam logic [4:0] INV_G          = 5'd2;
  localparam logic [4:0] INV_NG         = 5'd3;
  localparam logic [4:0] INV_NG_ASID    = 5'd4;
  localparam logic [4:0] INV_NG_ASID_VA = 5'd5;
  localparam logic [4:0] INV_GA_VA      = 5'd6;

  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic        e;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef enum logic {ST_IDLE, ST_SWEEP} sweep_st_t;

endpackage

// File: rtl/tlb_match.sv
// Per-entry compare: page-size aware VPN match and ASID equality (e/g qualified by caller).
module tlb_match
  import tlb_pkg::*;
(
  input  logic [18:0] vppn,
  input  logic [5:0]  ps,
  input  logic [9:0]  ent_asid,
  input  logic [19:0] va,
  input  logic [9:0]  asid,
  output logic        va_hit,
  output logic        asid_hit
);

  always_comb begin
    va_hit = 1'b0;
    if (ps == PS_4K)      va_hit = (vppn == va[19:1]);
    else if (ps == PS_2M) va_hit = (vppn[18:9] == va[19:10]);
  end

  assign asid_hit = (ent_asid == asid);

endmodule

// File: rtl/tlb_resp.sv
// TLB responder: 1-cycle lookup, TLBWR/TLBFILL write port, INVTLB sweep engine.
// Define TLB_RANDFILL_EN to take fill_idx from an 8-bit LFSR instead of a round-robin counter.
module tlb_resp
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [19:0]               req_va,
  input  logic [9:0]                req_asid,
  output logic                      resp_valid,
  output logic                      resp_found,
  output logic [$clog2(TLBNUM)-1:0] resp_idx,
  output logic [19:0]               resp_pfn,
  output logic                      resp_v,
  output logic                      resp_d,
  output logic [1:0]                resp_plv,
  output logic [1:0]                resp_mat,
  input  logic                      we,
  input  logic                      w_fill,
  input  logic [$clog2(TLBNUM)-1:0] w_idx,
  input  tlb_entry_t                w_entry,
  output logic [$clog2(TLBNUM)-1:0] fill_idx,
  input  logic                      inv_valid,
  input  logic [4:0]                inv_op,
  input  logic [9:0]                inv_asid,
  input  logic [19:0]               inv_va,
  output logic                      busy,
  output logic                      inv_done
);

  localparam int IW = $clog2(TLBNUM);
  localparam logic [IW-1:0] LAST = IW'(TLBNUM - 1);

  tlb_entry_t    tlb [TLBNUM];
  sweep_st_t     state, state_nxt;
  logic [IW-1:0] sw_idx;
  logic [4:0]    op_q;
  logic [9:0]    asid_q;
  logic [19:0]   va_q;

  logic          accept, wr_ok;
  logic [IW-1:0] wr_idx;

  assign req_ready = !busy;
  assign accept    = req_valid & req_ready;
  assign wr_ok     = we & !busy;
  assign wr_idx    = w_fill ? fill_idx : w_idx;

  // ---------------- lookup ----------------
  logic [TLBNUM-1:0] l_va, l_asid, l_hit;

  for (genvar i = 0; i < TLBNUM; i++) begin : g_lane
    tlb_match u_match (
      .vppn     (tlb[i].vppn),
      .ps       (tlb[i].ps),
      .ent_asid (tlb[i].asid),
      .va       (req_va),
      .asid     (req_asid),
      .va_hit   (l_va[i]),
      .asid_hit (l_asid[i])
    );
    assign l_hit[i] = tlb[i].e & (tlb[i].g | l_asid[i]) & l_va[i];
  end

  logic          hit_any, odd, is_2m;
  logic [IW-1:0] hit_idx;
  logic [19:0]   ppn_sel, pfn;

  // Descending scan so the lowest matching index is the last one assigned.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (l_hit[i]) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    is_2m   = (tlb[hit_idx].ps == PS_2M);
    odd     = is_2m ? req_va[9] : req_va[0];
    ppn_sel = odd ? tlb[hit_idx].ppn1 : tlb[hit_idx].ppn0;
    pfn     = is_2m ? {ppn_sel[19:9], req_va[8:0]} : ppn_sel;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid <= 1'b0;
      resp_found <= 1'b0;
      resp_idx   <= '0;
      resp_pfn   <= '0;
      resp_v     <= 1'b0;
      resp_d     <= 1'b0;
      resp_plv   <= '0;
      resp_mat   <= '0;
    end else begin
      resp_valid <= accept;
      if (accept) begin
        resp_found <= hit_any;
        resp_idx   <= hit_idx;
        resp_pfn   <= hit_any ? pfn : '0;
        resp_v     <= hit_any & (odd ? tlb[hit_idx].v1 : tlb[hit_idx].v0);
        resp_d     <= hit_any & (odd ? tlb[hit_idx].d1 : tlb[hit_idx].d0);
        resp_plv   <= hit_any ? (odd ? tlb[hit_idx].plv1 : tlb[hit_idx].plv0) : 2'b00;
        resp_mat   <= hit_any ? (odd ? tlb[hit_idx].mat1 : tlb[hit_idx].mat0) : 2'b00;
      end
    end
  end

  // ---------------- INVTLB sweep ----------------
  logic s_va, s_asid, s_hit;

  tlb_match u_sweep (
    .vppn     (tlb[sw_idx].vppn),
    .ps       (tlb[sw_idx].ps),
    .ent_asid (tlb[sw_idx].asid),
    .va       (va_q),
    .asid     (asid_q),
    .va_hit   (s_va),
    .asid_hit (s_asid)
  );

  always_comb begin
    s_hit = 1'b0;
    case (op_q)
      INV_ALL0, INV_ALL1: s_hit = 1'b1;
      INV_G:              s_hit = tlb[sw_idx].g;
      INV_NG:             s_hit = !tlb[sw_idx].g;
      INV_NG_ASID:        s_hit = !tlb[sw_idx].g & s_asid;
      INV_NG_ASID_VA:     s_hit = !tlb[sw_idx].g & s_asid & s_va;
      INV_GA_VA:          s_hit = (tlb[sw_idx].g | s_asid) & s_va;
      default:            s_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (inv_valid)      state_nxt = ST_SWEEP;
      ST_SWEEP: if (sw_idx == LAST) state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == ST_SWEEP);
    inv_done = (state == ST_SWEEP) && (sw_idx == LAST);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_idx <= '0;
      op_q   <= '0;
      asid_q <= '0;
      va_q   <= '0;
    end else if (state == ST_IDLE) begin
      sw_idx <= '0;
      if (inv_valid) begin
        op_q   <= inv_op;
        asid_q <= inv_asid;
        va_q   <= inv_va;
      end
    end else begin
      sw_idx <= (sw_idx == LAST) ? '0 : sw_idx + IW'(1);
    end
  end

  // ---------------- entry storage ----------------
  // Writes are gated off while busy, so they never collide with sweep clears.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TLBNUM; i++) tlb[i] <= '0;
    end else begin
      if (wr_ok)          tlb[wr_idx]     <= w_entry;
      if (busy && s_hit)  tlb[sw_idx].e   <= 1'b0;
    end
  end

  // ---------------- fill index ----------------
`ifdef TLB_RANDFILL_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= 8'hA5;
    else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign fill_idx = lfsr[IW-1:0];
`else
  logic [IW-1:0] fill_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)              fill_cnt <= '0;
    else if (wr_ok && w_fill) fill_cnt <= fill_cnt + IW'(1);
  end

  assign fill_idx = fill_cnt;
`endif

endmodule

// File: tb/tb_tlb_resp.sv
// Directed bench for tlb_resp: lookups, page sizes, priority, write port, INVTLB sweeps, reset.
module tb_tlb_resp;
  import tlb_pkg::*;

`ifdef TLB_RANDFILL_EN
  localparam logic [3:0] RST_FILL = 4'd5;
`else
  localparam logic [3:0] RST_FILL = 4'd0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready;
  logic [19:0] req_va;
  logic [9:0]  req_asid;
  logic        resp_valid, resp_found, resp_v, resp_d;
  logic [3:0]  resp_idx;
  logic [19:0] resp_pfn;
  logic [1:0]  resp_plv, resp_mat;
  logic        we, w_fill;
  logic [3:0]  w_idx, fill_idx;
  tlb_entry_t  w_entry;
  logic        inv_valid;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [19:0] inv_va;
  logic        busy, inv_done;

  int n_tests = 0;
  int n_fail  = 0;

  tlb_resp #(.TLBNUM(16)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va), .req_asid(req_asid),
    .resp_valid(resp_valid), .resp_found(resp_found), .resp_idx(resp_idx), .resp_pfn(resp_pfn),
    .resp_v(resp_v), .resp_d(resp_d), .resp_plv(resp_plv), .resp_mat(resp_mat),
    .we(we), .w_fill(w_fill), .w_idx(w_idx), .w_entry(w_entry), .fill_idx(fill_idx),
    .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
    .busy(busy), .inv_done(inv_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input logic f, input logic [3:0] idx,
                          input logic [19:0] pfn);
    check({tag, ".valid"}, 32'(resp_valid), 32'd1);
    check({tag, ".found"}, 32'(resp_found), 32'(f));
    check({tag, ".idx"},   32'(resp_idx),   32'(idx));
    check({tag, ".pfn"},   32'(resp_pfn),   32'(pfn));
  endtask

  function automatic tlb_entry_t mk(input logic [18:0] vppn, input logic [5:0] ps,
                                    input logic g, input logic [9:0] asid,
                                    input logic [19:0] p0, input logic [19:0] p1);
    tlb_entry_t t;
    t      = '0;
    t.vppn = vppn; t.ps = ps; t.g = g; t.asid = asid; t.e = 1'b1;
    t.ppn0 = p0;   t.v0 = 1'b1;
    t.ppn1 = p1;   t.v1 = 1'b1;
    return t;
  endfunction

  task automatic wr(input logic [3:0] idx, input tlb_entry_t t);
    we = 1'b1; w_fill = 1'b0; w_idx = idx; w_entry = t;
    tick();
    we = 1'b0;
  endtask

  task automatic lookup(input logic [19:0] va, input logic [9:0] asid);
    req_valid = 1'b1; req_va = va; req_asid = asid;
    tick();
    req_valid = 1'b0;
  endtask

  // Runs one sweep; optionally holds a dropped write and a stalled lookup during it.
  task automatic run_sweep(input logic [4:0] op, input logic [9:0] asid, input logic [19:0] va,
                           input bit poke, output int nb, output int nd, output int dat,
                           output int nrdy, output int nresp);
    inv_valid = 1'b1; inv_op = op; inv_asid = asid; inv_va = va;
    tick();
    inv_valid = 1'b0;
    if (poke) begin
      we = 1'b1; w_fill = 1'b0; w_idx = 4'd5;
      w_entry = mk(19'h00100, PS_4K, 1'b1, 10'd0, 20'h55555, 20'h55555);
      req_valid = 1'b1; req_va = 20'h000C2; req_asid = 10'd5;
    end
    nb = 0; nd = 0; dat = 0; nrdy = 0; nresp = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      nb++;
      if (inv_done) begin nd++; dat = nb; end
      if (req_ready) nrdy++;
      if (resp_valid) nresp++;
      tick();
    end
    we = 1'b0;
  endtask

  initial begin
    tlb_entry_t t;
    int nb, nd, dat, nrdy, nresp;

    resetn = 1'b0; req_valid = 1'b0; req_va = '0; req_asid = '0;
    we = 1'b0; w_fill = 1'b0; w_idx = '0; w_entry = '0;
    inv_valid = 1'b0; inv_op = '0; inv_asid = '0; inv_va = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_found", 32'(resp_found), 32'd0);
    check("rst.busy",       32'(busy),       32'd0);
    check("rst.inv_done",   32'(inv_done),   32'd0);
    check("rst.req_ready",  32'(req_ready),  32'd1);
    check("rst.fill_idx",   32'(fill_idx),   32'(RST_FILL));
    resetn = 1'b1;
    tick();

    lookup(20'h00021, 10'd5);
    chk_resp("empty", 1'b0, 4'd0, 20'h0);

    // 4K entry at idx 3, odd and even pages with distinct attributes
    t = mk(19'h00010, PS_4K, 1'b0, 10'd5, 20'h00AAA, 20'h80001);
    t.d1 = 1'b1; t.plv1 = 2'd3; t.mat1 = 2'd1;
    t.d0 = 1'b0; t.plv0 = 2'd0; t.mat0 = 2'd2;
    wr(4'd3, t);
    lookup(20'h00021, 10'd5);
    chk_resp("4k_odd", 1'b1, 4'd3, 20'h80001);
    check("4k_odd.v",   32'(resp_v),   32'd1);
    check("4k_odd.d",   32'(resp_d),   32'd1);
    check("4k_odd.plv", 32'(resp_plv), 32'd3);
    check("4k_odd.mat", 32'(resp_mat), 32'd1);
    lookup(20'h00020, 10'd5);
    chk_resp("4k_even", 1'b1, 4'd3, 20'h00AAA);
    check("4k_even.d",   32'(resp_d),   32'd0);
    check("4k_even.mat", 32'(resp_mat), 32'd2);
    lookup(20'h00021, 10'd5);
    lookup(20'h00021, 10'd6);
    chk_resp("asid_miss", 1'b0, 4'd0, 20'h0);
    check("asid_miss.v",   32'(resp_v),   32'd0);
    check("asid_miss.d",   32'(resp_d),   32'd0);
    check("asid_miss.plv", 32'(resp_plv), 32'd0);
    check("asid_miss.mat", 32'(resp_mat), 32'd0);
    t.g = 1'b1;
    wr(4'd3, t);
    lookup(20'h00021, 10'd6);
    chk_resp("global_hit", 1'b1, 4'd3, 20'h80001);

    // 2M page: PFN low bits come from the VA
    wr(4'd9, mk(19'h00400, PS_2M, 1'b1, 10'd0, 20'h10000, 20'h20000));
    lookup(20'h00812, 10'd0);
    chk_resp("2m", 1'b1, 4'd9, 20'h10012);

    // Lookup in the same cycle as a write sees the old contents
    we = 1'b1; w_fill = 1'b0; w_idx = 4'd4;
    w_entry = mk(19'h00030, PS_4K, 1'b0, 10'd5, 20'h0BEEF, 20'h0CAFE);
    req_valid = 1'b1; req_va = 20'h00060; req_asid = 10'd5;
    tick();
    we = 1'b0; req_valid = 1'b0;
    chk_resp("wr_same_cyc", 1'b0, 4'd0, 20'h0);
    lookup(20'h00060, 10'd5);
    chk_resp("wr_after", 1'b1, 4'd4, 20'h0BEEF);

    // Two matching entries: lowest index wins
    wr(4'd7, mk(19'h00050, PS_4K, 1'b1, 10'd0, 20'h77777, 20'h77778));
    wr(4'd2, mk(19'h00050, PS_4K, 1'b1, 10'd0, 20'h22222, 20'h22223));
    lookup(20'h000A0, 10'd9);
    chk_resp("multi_hit", 1'b1, 4'd2, 20'h22222);

    // Unsupported page size never matches
    wr(4'd10, mk(19'h00070, 6'd13, 1'b1, 10'd0, 20'h0ABCD, 20'h0ABCD));
    lookup(20'h000E0, 10'd0);
    chk_resp("bad_ps", 1'b0, 4'd0, 20'h0);

    // Back-to-back lookups, then hold
    req_valid = 1'b1; req_va = 20'h00021; req_asid = 10'd5;
    tick();
    chk_resp("b2b_0", 1'b1, 4'd3, 20'h80001);
    req_va = 20'h00812;
    tick();
    req_valid = 1'b0;
    chk_resp("b2b_1", 1'b1, 4'd9, 20'h10012);
    tick();
    check("hold.valid", 32'(resp_valid), 32'd0);
    check("hold.idx",   32'(resp_idx),   32'd9);
    check("hold.pfn",   32'(resp_pfn),   32'h10012);

`ifndef TLB_RANDFILL_EN
    // TLBFILL uses the round-robin index, ignoring w_idx
    we = 1'b1; w_fill = 1'b1; w_idx = 4'd15;
    w_entry = mk(19'h00090, PS_4K, 1'b1, 10'd0, 20'h12345, 20'h12346);
    tick();
    we = 1'b0; w_fill = 1'b0;
    check("fill.idx_next", 32'(fill_idx), 32'd1);
    lookup(20'h00120, 10'd0);
    chk_resp("fill.lookup", 1'b1, 4'd0, 20'h12345);
`endif

    // INVTLB op 4, asid 5: only g=0/asid=5 entries are cleared
    wr(4'd11, mk(19'h00060, PS_4K, 1'b0, 10'd6, 20'h0CCCC, 20'h0CCCD));
    wr(4'd12, mk(19'h00061, PS_4K, 1'b0, 10'd5, 20'h0DDDD, 20'h0DDDE));
    lookup(20'h000C2, 10'd5);
    chk_resp("pre_inv.idx12", 1'b1, 4'd12, 20'h0DDDD);
    run_sweep(5'd4, 10'd5, 20'h0, 1'b1, nb, nd, dat, nrdy, nresp);
    check("inv4.busy_cycles", 32'(nb),    32'd16);
    check("inv4.done_pulses", 32'(nd),    32'd1);
    check("inv4.done_at",     32'(dat),   32'd16);
    check("inv4.ready_high",  32'(nrdy),  32'd0);
    check("inv4.resp_during", 32'(nresp), 32'd0);
    check("inv4.busy_after",  32'(busy),  32'd0);
    tick();
    req_valid = 1'b0;
    chk_resp("inv4.first_after", 1'b0, 4'd0, 20'h0);
    lookup(20'h00060, 10'd5);
    chk_resp("inv4.idx4_gone", 1'b0, 4'd0, 20'h0);
    lookup(20'h000C0, 10'd6);
    chk_resp("inv4.idx11_kept", 1'b1, 4'd11, 20'h0CCCC);
    lookup(20'h00021, 10'd5);
    chk_resp("inv4.idx3_kept", 1'b1, 4'd3, 20'h80001);
    lookup(20'h00200, 10'd0);
    chk_resp("inv4.write_dropped", 1'b0, 4'd0, 20'h0);

    // INVTLB op 6 with a VA inside the 2M page
    run_sweep(5'd6, 10'd0, 20'h00812, 1'b0, nb, nd, dat, nrdy, nresp);
    check("inv6.busy_cycles", 32'(nb), 32'd16);
    check("inv6.done_pulses", 32'(nd), 32'd1);
    lookup(20'h00812, 10'd0);
    chk_resp("inv6.2m_gone", 1'b0, 4'd0, 20'h0);
    lookup(20'h000A0, 10'd0);
    chk_resp("inv6.idx2_kept", 1'b1, 4'd2, 20'h22222);

    // Reset in sweep cycle 7 of an op-7 (no-match) sweep
    inv_valid = 1'b1; inv_op = 5'd7; inv_asid = '0; inv_va = '0;
    tick();
    inv_valid = 1'b0;
    repeat (7) tick();
    check("rst_mid.busy_before", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_mid.busy",      32'(busy),      32'd0);
    check("rst_mid.inv_done",  32'(inv_done),  32'd0);
    check("rst_mid.fill_idx",  32'(fill_idx),  32'(RST_FILL));
    check("rst_mid.resp_found", 32'(resp_found), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    check("rst_mid.ready", 32'(req_ready), 32'd1);
    lookup(20'h00021, 10'd5);
    chk_resp("rst_mid.idx3", 1'b0, 4'd0, 20'h0);
    lookup(20'h000A0, 10'd0);
    chk_resp("rst_mid.idx2", 1'b0, 4'd0, 20'h0);
    lookup(20'h000C0, 10'd6);
    chk_resp("rst_mid.idx11", 1'b0, 4'd0, 20'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
